// File: rtl/host_bridge_pkg.sv
// rtl/host_bridge_pkg.sv - shared FSM states and packet framing constants for host_bus_bridge
package host_bridge_pkg;

  // Bridge FSM states: four header bytes, then the write or read data phase.
  typedef enum logic [3:0] {
    CMD,
    ADDR_MID,
    ADDR_LO,
    COUNT,
    WR_DATA,
    WR_STROBE,
    RD_ADDR,
    RD_WAIT,
    RD_SEND
  } bridge_state_t;

  // Bit of byte0 carrying the opcode (1 = write, 0 = read).
  localparam int OP_BIT = 7;

  // Header bytes in front of any payload: cmd/addr_hi, addr_mid, addr_lo, count.
  localparam int HEADER_LEN = 4;

  // Address bits carried in byte0 below the opcode bit.
  localparam int ADDR_HI_BITS = 7;

endpackage

// File: rtl/host_bus_bridge.sv
// rtl/host_bus_bridge.sv - host link packet decoder driving a shared memory_manager bus
module host_bus_bridge
  import host_bridge_pkg::*;
#(
  parameter int DATA_WIDTH    = 8,
  parameter int ADDRESS_WIDTH = 23,
  parameter int READ_LATENCY  = 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [DATA_WIDTH-1:0]    rx_data,
  input  logic                     rx_valid,
  output logic                     rx_ready,
  output logic [DATA_WIDTH-1:0]    tx_data,
  output logic                     tx_valid,
  input  logic                     tx_ready,
  inout  wire  [DATA_WIDTH-1:0]    data,
  output logic [ADDRESS_WIDTH-1:0] address,
  output logic                     wren
);

  bridge_state_t           state;
  logic                    op_write;
  logic [ADDR_HI_BITS-1:0] hdr_hi;
  logic [7:0]              hdr_mid;
  logic [ADDRESS_WIDTH-1:0] cur_addr;
  logic [DATA_WIDTH-1:0]   remaining;
  logic [DATA_WIDTH-1:0]   wr_data;
  logic [1:0]              wait_cnt;
  logic                    rx_fire;

  assign rx_fire = rx_valid && rx_ready;

  // The bus is only ours during the single write-strobe cycle.
  assign data = wren ? wr_data : {DATA_WIDTH{1'bz}};

  // Packet FSM with registered handshake, bus and read-back outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= CMD;
      op_write  <= 1'b0;
      hdr_hi    <= '0;
      hdr_mid   <= '0;
      cur_addr  <= '0;
      remaining <= '0;
      wr_data   <= '0;
      wait_cnt  <= '0;
      rx_ready  <= 1'b0;
      tx_data   <= '0;
      tx_valid  <= 1'b0;
      address   <= '0;
      wren      <= 1'b0;
    end else begin
      case (state)
        CMD: begin
          rx_ready <= 1'b1;
          if (rx_fire) begin
            op_write <= rx_data[OP_BIT];
            hdr_hi   <= rx_data[ADDR_HI_BITS-1:0];
            state    <= ADDR_MID;
          end
        end
        ADDR_MID: begin
          if (rx_fire) begin
            hdr_mid <= rx_data[7:0];
            state   <= ADDR_LO;
          end
        end
        ADDR_LO: begin
          if (rx_fire) begin
            cur_addr <= ADDRESS_WIDTH'({hdr_hi, hdr_mid, rx_data[7:0]});
            state    <= COUNT;
          end
        end
        COUNT: begin
          if (rx_fire) begin
            remaining <= rx_data;
            if (op_write) begin
              state <= WR_DATA;
            end else begin
              rx_ready <= 1'b0;
              address  <= cur_addr;
              state    <= RD_ADDR;
            end
          end
        end
        WR_DATA: begin
          // rx_valid gaps simply leave us parked here.
          if (rx_fire) begin
            wr_data  <= rx_data;
            address  <= cur_addr;
            wren     <= 1'b1;
            rx_ready <= 1'b0;
            state    <= WR_STROBE;
          end
        end
        WR_STROBE: begin
          wren     <= 1'b0;
          cur_addr <= cur_addr + ADDRESS_WIDTH'(1);
          rx_ready <= 1'b1;
          if (remaining == '0) begin
            state <= CMD;
          end else begin
            remaining <= remaining - DATA_WIDTH'(1);
            state     <= WR_DATA;
          end
        end
        RD_ADDR: begin
          // With latency 1 the address cycle itself is the last bus cycle.
          if (READ_LATENCY == 1) begin
            tx_data  <= data;
            tx_valid <= 1'b1;
            state    <= RD_SEND;
          end else begin
            wait_cnt <= 2'(READ_LATENCY - 2);
            state    <= RD_WAIT;
          end
        end
        RD_WAIT: begin
          if (wait_cnt == 2'd0) begin
            tx_data  <= data;
            tx_valid <= 1'b1;
            state    <= RD_SEND;
          end else begin
            wait_cnt <= wait_cnt - 2'd1;
          end
        end
        RD_SEND: begin
          if (tx_ready) begin
            tx_valid <= 1'b0;
            cur_addr <= cur_addr + ADDRESS_WIDTH'(1);
            if (remaining == '0) begin
              rx_ready <= 1'b1;
              state    <= CMD;
            end else begin
              remaining <= remaining - DATA_WIDTH'(1);
              address   <= cur_addr + ADDRESS_WIDTH'(1);
              state     <= RD_ADDR;
            end
          end
        end
        default: begin
          wren     <= 1'b0;
          tx_valid <= 1'b0;
          rx_ready <= 1'b0;
          state    <= CMD;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_host_bus_bridge.sv
// tb/tb_host_bus_bridge.sv - randomized scoreboard bench for host_bus_bridge
module tb_host_bus_bridge;

  localparam int DW = 8;
  localparam int AW = 23;
  localparam int RL = 3;
  localparam int ASPACE = 1 << AW;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [DW-1:0] rx_data;
  logic          rx_valid;
  wire           rx_ready;
  wire  [DW-1:0] tx_data;
  wire           tx_valid;
  logic          tx_ready;
  wire  [DW-1:0] data;
  wire  [AW-1:0] address;
  wire           wren;

  always #5 clk = ~clk;

  host_bus_bridge #(.DATA_WIDTH(DW), .ADDRESS_WIDTH(AW), .READ_LATENCY(RL)) dut (
    .clk(clk), .rst_n(rst_n),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .data(data), .address(address), .wren(wren)
  );

  // Memory model: returns addr[7:0] once the address has been presented for RL cycles.
  int unsigned   age = 0;
  logic [AW-1:0] last_seen = '0;
  always @(negedge clk) begin
    if (address == last_seen) begin
      if (age < 100) age <= age + 1;
    end else begin
      age <= 1;
    end
    last_seen <= address;
  end
  assign data = wren ? {DW{1'bz}} : ((age >= RL) ? address[7:0] : 8'hEE);

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [AW-1:0] a;
    logic [DW-1:0] d;
  } wr_t;

  wr_t           wr_q[$];
  logic [DW-1:0] tx_q[$];
  logic          hold_tx = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Monitor: pops the scoreboard whenever the DUT strobes the bus or hands over a tx byte.
  logic          prev_tv = 1'b0;
  logic          prev_hs = 1'b0;
  logic          prev_wren = 1'b0;
  logic [DW-1:0] prev_td = '0;
  always @(negedge clk) begin
    if (rst_n) begin
      if (wren) begin
        chk("wren_single_cycle", {31'b0, prev_wren}, 32'd0);
        if (wr_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_wren actual addr=%0h data=%0h required=no strobe", address, data);
        end else begin
          chk("wr_addr", {9'b0, address}, {9'b0, wr_q[0].a});
          chk("wr_data", {24'b0, data}, {24'b0, wr_q[0].d});
          void'(wr_q.pop_front());
        end
      end
      if (prev_tv && !prev_hs) begin
        chk("tx_valid_hold", {31'b0, tx_valid}, 32'd1);
        chk("tx_data_hold", {24'b0, tx_data}, {24'b0, prev_td});
      end
      if (tx_valid) begin
        chk("rx_ready_low_in_read", {31'b0, rx_ready}, 32'd0);
        if (tx_ready) begin
          if (tx_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_tx actual=%0h required=no byte", tx_data);
          end else begin
            chk("tx_byte", {24'b0, tx_data}, {24'b0, tx_q[0]});
            void'(tx_q.pop_front());
          end
        end
      end
      prev_tv   <= tx_valid;
      prev_hs   <= tx_valid && tx_ready;
      prev_td   <= tx_data;
      prev_wren <= wren;
    end else begin
      prev_tv   <= 1'b0;
      prev_hs   <= 1'b0;
      prev_wren <= 1'b0;
    end
  end

  // Host-side consumer with random backpressure, or held off when hold_tx is set.
  initial begin
    tx_ready = 1'b0;
    forever begin
      @(posedge clk);
      #2;
      tx_ready = hold_tx ? 1'b0 : ($urandom_range(0, 3) != 0);
    end
  end

  task automatic send_byte(input logic [DW-1:0] b);
    int n = 0;
    if ($urandom_range(0, 3) == 0) begin
      repeat ($urandom_range(1, 3)) @(posedge clk);
      #1;
    end
    rx_data  = b;
    rx_valid = 1'b1;
    do begin
      @(posedge clk);
      n++;
    end while (!rx_ready && n < 3000);
    if (n >= 3000) begin
      checks++;
      errors++;
      $display("FAIL rx_accept_timeout actual=rx_ready low required=byte accepted");
    end
    #1;
    rx_valid = 1'b0;
  endtask

  task automatic send_header(input logic op, input logic [AW-1:0] a, input int n);
    send_byte({op, a[22:16]});
    send_byte(a[15:8]);
    send_byte(a[7:0]);
    send_byte(8'(n - 1));
  endtask

  task automatic do_write(input logic [AW-1:0] a, input logic [DW-1:0] pay[$]);
    wr_t w;
    for (int i = 0; i < pay.size(); i++) begin
      w.a = AW'((int'(a) + i) % ASPACE);
      w.d = pay[i];
      wr_q.push_back(w);
    end
    send_header(1'b1, a, pay.size());
    for (int i = 0; i < pay.size(); i++) send_byte(pay[i]);
  endtask

  task automatic do_read(input logic [AW-1:0] a, input int n);
    for (int i = 0; i < n; i++) tx_q.push_back(8'(((int'(a) + i) % ASPACE) & 8'hFF));
    send_header(1'b0, a, n);
  endtask

  task automatic drain();
    int n = 0;
    while ((wr_q.size() != 0 || tx_q.size() != 0) && n < 5000) begin
      @(posedge clk);
      n++;
    end
    repeat (3) @(posedge clk);
    #1;
    chk("scoreboard_drained", wr_q.size() + tx_q.size(), 32'd0);
  endtask

  initial begin
    logic [DW-1:0] pay[$];
    logic [AW-1:0] a;
    int            n;
    int            k;
    wr_t           w;

    rst_n    = 1'b0;
    rx_valid = 1'b0;
    rx_data  = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_rx_ready", {31'b0, rx_ready}, 32'd0);
    chk("reset_tx_valid", {31'b0, tx_valid}, 32'd0);
    chk("reset_wren", {31'b0, wren}, 32'd0);
    chk("reset_address", {9'b0, address}, 32'd0);
    chk("reset_tx_data", {24'b0, tx_data}, 32'd0);
    rst_n = 1'b1;
    #1;
    chk("rx_ready_before_first_edge", {31'b0, rx_ready}, 32'd0);
    @(posedge clk);
    #1;
    chk("rx_ready_first_edge", {31'b0, rx_ready}, 32'd1);

    // Two-byte write from address 0.
    pay = {8'h05, 8'h00};
    do_write(23'h000000, pay);
    drain();

    // Three-byte read from 0x10.
    do_read(23'h000010, 3);
    drain();

    // Write across the top of the address space.
    pay = {8'hAA, 8'hBB};
    do_write(23'h7FFFFF, pay);
    drain();

    // Single-byte read held off by the host for 10 cycles.
    hold_tx = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    do_read(23'h0ABC42, 1);
    k = 0;
    while (!tx_valid && k < 200) begin
      @(posedge clk);
      #1;
      k++;
    end
    chk("held_read_tx_valid", {31'b0, tx_valid}, 32'd1);
    repeat (10) @(posedge clk);
    #1;
    chk("held_read_still_pending", tx_q.size(), 32'd1);
    hold_tx = 1'b0;
    drain();

    // Reset while waiting in the middle of a 4-byte write.
    w.a = 23'h012340;
    w.d = 8'h3C;
    wr_q.push_back(w);
    send_header(1'b1, 23'h012340, 4);
    send_byte(8'h3C);
    repeat (4) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk("midreset_wren", {31'b0, wren}, 32'd0);
    chk("midreset_rx_ready", {31'b0, rx_ready}, 32'd0);
    chk("midreset_address", {9'b0, address}, 32'd0);
    chk("midreset_first_strobe_seen", wr_q.size(), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("postreset_rx_ready", {31'b0, rx_ready}, 32'd1);
    pay = {8'h11, 8'h22, 8'h33};
    do_write(23'h000200, pay);
    drain();

    // Randomized packet mix, including addresses near the wrap point.
    for (int p = 0; p < 30; p++) begin
      if ($urandom_range(0, 3) == 0) a = AW'(ASPACE - 1 - int'($urandom_range(0, 3)));
      else a = AW'($urandom_range(0, ASPACE - 1));
      n = $urandom_range(1, 12);
      if ($urandom_range(0, 1) == 1) begin
        pay = {};
        for (int i = 0; i < n; i++) pay.push_back(8'($urandom_range(0, 255)));
        do_write(a, pay);
      end else begin
        do_read(a, n);
      end
    end
    drain();

    // Maximum-length read crossing the wrap point.
    do_read(23'h7FFF80, 256);
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout actual=still running required=finished");
    $fatal(1);
  end

endmodule

// File: doc/host_bus_bridge.md
HOST_BUS_BRIDGE -- requirements
Module: host_bus_bridge

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, host bus byte width.
REQ-002 SHALL have parameter ADDRESS_WIDTH, default 23, host bus address width.
REQ-003 SHALL have parameter READ_LATENCY, default 1 (legal 1..4), cycles from read address drive to valid data on the bus.
REQ-004 SHALL have port clk  input  1  sole clock; all logic on rising edge.
REQ-005 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port rx_data  input  DATA_WIDTH  command/payload byte from the host link.
REQ-007 SHALL have port rx_valid  input  1  rx_data valid.
REQ-008 SHALL have port rx_ready  output  1  byte accepted when rx_valid and rx_ready are both high.
REQ-009 SHALL have port tx_data  output  DATA_WIDTH  read-back byte to the host link.
REQ-010 SHALL have port tx_valid  output  1  tx_data valid.
REQ-011 SHALL have port tx_ready  input  1  tx byte consumed when tx_valid and tx_ready are both high.
REQ-012 SHALL have port data  inout  DATA_WIDTH  shared bus to memory_manager; driven only while wren is high, else high-Z.
REQ-013 SHALL have port address  output  ADDRESS_WIDTH  bus address to memory_manager.
REQ-014 SHALL have port wren  output  1  bus write strobe to memory_manager.

Function
REQ-015 Packet format SHALL be: byte0 = {op bit7 (1=write, 0=read), addr[22:16]}, byte1 = addr[15:8], byte2 = addr[7:0], byte3 = N-1 (1..256 bytes), then N payload bytes for a write only.
REQ-016 FSM states SHALL be CMD, ADDR_MID, ADDR_LO, COUNT, WR_DATA, WR_STROBE, RD_ADDR, RD_WAIT, RD_SEND; CMD->ADDR_MID->ADDR_LO->COUNT each on one accepted byte.
REQ-017 From COUNT SHALL go to WR_DATA (write) or RD_ADDR (read).
REQ-018 rx_ready SHALL be high in CMD, ADDR_MID, ADDR_LO, COUNT and WR_DATA only.
REQ-019 Write: byte accepted in WR_DATA -> next cycle WR_STROBE drives data=byte, address=current, wren=1 for exactly one cycle.
REQ-020 After WR_STROBE, address SHALL increment by 1 and the remaining count SHALL decrement; remaining 0 -> CMD, else -> WR_DATA.
REQ-021 Read: RD_ADDR drives address with wren=0 for one cycle, RD_WAIT holds READ_LATENCY-1 further cycles, data sampled on the last bus cycle into tx_data.
REQ-022 RD_SEND SHALL hold tx_valid=1 and tx_data stable until tx_ready; then increment address, decrement count; remaining 0 -> CMD, else -> RD_ADDR.
REQ-023 Address increment SHALL wrap modulo 2^ADDRESS_WIDTH (0x7FFFFF -> 0x000000) with no error.
REQ-024 Outside a strobe, address SHALL hold its last value and wren SHALL be 0.
REQ-025 Minimum write throughput SHALL be one byte per 2 cycles; rx_valid gaps stall in WR_DATA indefinitely.
REQ-026 tx_ready asserted while tx_valid is low SHALL have no effect.

Reset
REQ-027 rst_n low SHALL immediately force state CMD, wren=0, data high-Z, rx_ready=0, tx_valid=0, tx_data=0, address=0, counters=0.
REQ-028 Reset mid-packet SHALL abort the packet with no further bus strobe; the first byte after release is decoded as byte0.
REQ-029 rx_ready SHALL go high on the first clk edge after rst_n release.

Structure
REQ-030 FSM state enum, opcode bit position and header length constant SHALL live in shared package host_bridge_pkg.
REQ-031 No sub-module SHALL be used; tri-state driver is a continuous assign in this module.

Verification
REQ-032 Write 0x80,0x00,0x00,0x01,0x05,0x00 -> two wren pulses: addr 0 data 0x05, addr 1 data 0x00; data high-Z otherwise.
REQ-033 Read 0x00,0x00,0x10,0x02, bus model returns addr[7:0] -> tx bytes 0x10,0x11,0x12, then back to CMD.
REQ-034 Write 0xFF,0xFF,0xFF,0x01,0xAA,0xBB -> strobes at 0x7FFFFF (0xAA) then 0x000000 (0xBB).
REQ-035 Read of 1 byte with tx_ready low for 10 cycles -> tx_valid and tx_data held stable, rx_ready low throughout.
REQ-036 rst_n pulsed low during WR_DATA of a 4-byte write -> wren=0 immediately, no further strobes, next packet executes correctly.
